// File: rtl/data_cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package data_cache_pkg;

  localparam int DEFAULT_SETS = 16;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU,
    FILL
  } state_t;

  // Word stores touch every lane; byte stores touch only the addressed lane.
  function automatic logic [3:0] lane_be(input logic byte_acc, input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b1111;
    if (byte_acc) begin
      be = 4'b0001 << offset;
    end
    return be;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for one-word cache lines: asynchronous read,
// synchronous byte-enabled write.
module cache_line_array #(
  parameter int D_WIDTH = 32,
  parameter int SETS    = 16,
  parameter int IDX_W   = $clog2(SETS),
  parameter int TAG_W   = D_WIDTH - 2 - IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [D_WIDTH-1:0] rd_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [3:0]         wr_be,
  input  logic [D_WIDTH-1:0] wr_data
);

  logic [SETS-1:0]  valid_reg;
  logic [TAG_W-1:0] tag_mem [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
    end
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];

  // One storage array per byte lane so partial-word stores need no read-modify-write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [SETS];

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[gi]) begin
        lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
      end
    end

    assign rd_data[gi*8 +: 8] = lane_mem[rd_idx];
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// memory stage and main data memory.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int SETS    = DEFAULT_SETS,
  parameter int IDX_W   = $clog2(SETS),
  parameter int TAG_W   = D_WIDTH - 2 - IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_re,
  input  logic               cpu_we,
  input  logic               cpu_byte,
  input  logic [D_WIDTH-1:0] cpu_addr,
  input  logic [D_WIDTH-1:0] cpu_wdata,
  output logic [D_WIDTH-1:0] cpu_rdata,
  output logic               stall,
  output logic               mem_req,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_addr,
  output logic [3:0]         mem_be,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic               mem_ack,
  input  logic [D_WIDTH-1:0] mem_rdata
);

  state_t state_reg, state_next;

  logic               mem_req_reg, mem_we_reg, wr_hit_reg;
  logic [D_WIDTH-1:0] mem_addr_reg, mem_wdata_reg;
  logic [3:0]         mem_be_reg;

  logic [IDX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic               line_valid, hit;
  logic [TAG_W-1:0]   line_tag;
  logic [D_WIDTH-1:0] line_data;
  logic               wr_en;
  logic [3:0]         wr_be;
  logic [D_WIDTH-1:0] wr_data;
  logic [7:0]         sel_byte;

  assign cpu_idx = cpu_addr[IDX_W+1:2];
  assign cpu_tag = cpu_addr[D_WIDTH-1:IDX_W+2];
  assign hit     = line_valid && (line_tag == cpu_tag);

  // Fills and store-hit updates both target the line latched in mem_addr_reg.
  assign wr_en   = mem_ack && ((state_reg == RD_MISS) || (state_reg == WR_THRU && wr_hit_reg));
  assign wr_be   = (state_reg == RD_MISS) ? 4'b1111 : mem_be_reg;
  assign wr_data = (state_reg == RD_MISS) ? mem_rdata : mem_wdata_reg;

  cache_line_array #(
    .D_WIDTH (D_WIDTH),
    .SETS    (SETS),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (cpu_idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_idx   (mem_addr_reg[IDX_W+1:2]),
    .wr_tag   (mem_addr_reg[D_WIDTH-1:IDX_W+2]),
    .wr_be    (wr_be),
    .wr_data  (wr_data)
  );

  always_comb begin
    sel_byte = line_data[7:0];
    case (cpu_addr[1:0])
      2'd1:    sel_byte = line_data[15:8];
      2'd2:    sel_byte = line_data[23:16];
      2'd3:    sel_byte = line_data[31:24];
      default: sel_byte = line_data[7:0];
    endcase
  end

  assign cpu_rdata = cpu_byte ? {{(D_WIDTH-8){1'b0}}, sel_byte} : line_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cpu_we) begin
          stall      = 1'b1;
          state_next = WR_THRU;
        end else if (cpu_re && !hit) begin
          stall      = 1'b1;
          state_next = RD_MISS;
        end
      end
      RD_MISS: begin
        stall = 1'b1;
        if (mem_ack) state_next = FILL;
      end
      WR_THRU: begin
        // The store retires in the ack cycle itself.
        stall = ~mem_ack;
        if (mem_ack) state_next = IDLE;
      end
      FILL: begin
        stall      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_be_reg    <= '0;
      mem_wdata_reg <= '0;
      wr_hit_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu_we) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= {cpu_addr[D_WIDTH-1:2], 2'b00};
            mem_be_reg    <= lane_be(cpu_byte, cpu_addr[1:0]);
            mem_wdata_reg <= cpu_byte ? {(D_WIDTH/8){cpu_wdata[7:0]}} : cpu_wdata;
            wr_hit_reg    <= hit;
          end else if (cpu_re && !hit) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= {cpu_addr[D_WIDTH-1:2], 2'b00};
            mem_be_reg    <= '0;
            mem_wdata_reg <= '0;
            wr_hit_reg    <= 1'b0;
          end
        end
        RD_MISS, WR_THRU: begin
          if (mem_ack) begin
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_be    = mem_be_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule
